// File: rtl/avalon_pio_poller_pkg.sv
// Shared types and defaults for the PIO poller.
//   state_t      : poller FSM states
//   DEF_ADDR_W   : default master address width (byte addresses)
//   DEF_DATA_W   : default significant PIO data width
//   PIO_DATA_OFS : byte offset of the data register inside a PIO slave
package avalon_pio_poller_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 18;
    localparam int PIO_DATA_OFS = 0;

endpackage

// File: rtl/avalon_pio_poller_if.sv
// Avalon-MM bus between the poller (master) and the PIO slaves.
//   address, read, write, writedata : master -> slave
//   readdata (latency 1), waitrequest : slave -> master
interface avalon_pio_poller_if
    import avalon_pio_poller_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_pio_poller_poll_timer.sv
// Reloadable down-counter setting the poll interval.
//   clk, reset : clock, synchronous active-high reset (loads POLL_DIV-1)
//   load       : reload POLL_DIV-1 (wins over en)
//   en         : count down by one; sticks at zero
//   zero       : count is zero
module poll_timer
    import avalon_pio_poller_pkg::*;
#(
    parameter int POLL_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);
    // POLL_DIV-1 always fits in $clog2(POLL_DIV) bits; keep at least one bit.
    localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/avalon_pio_poller.sv
// Avalon-MM master that polls an input PIO data register every POLL_DIV
// cycles and, when the sampled value differs from the last one (or on the
// first poll after reset), writes it to an output PIO data register.
//   clk, reset : clock, synchronous active-high reset
//   enable     : run polling; sampled only while waiting between polls
//   avm        : Avalon-MM master port (readdata latency 1)
//   value      : last sampled PIO value
//   changed    : one-cycle pulse when a new value is captured
module avalon_pio_poller
    import avalon_pio_poller_pkg::*;
#(
    parameter int                POLL_DIV = 50000,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] SRC_ADDR = 16'h0000,
    parameter logic [ADDR_W-1:0] DST_ADDR = 16'h0010,
    parameter int                DATA_W   = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    avalon_pio_poller_if.master        avm,
    output logic [DATA_W-1:0]          value,
    output logic                       changed
);
    localparam logic [ADDR_W-1:0] SRC_REG = SRC_ADDR + ADDR_W'(PIO_DATA_OFS);

    state_t            state;
    logic              first_flag;
    logic              tmr_zero;
    logic              tmr_load;
    logic              tmr_en;
    logic [DATA_W-1:0] sample;

    // Upper readdata bits are don't-care.
    assign sample = avm.readdata[DATA_W-1:0];

    // Timer reloads exactly when WAIT is left, so every WAIT visit lasts POLL_DIV cycles.
    assign tmr_load = (state == WAIT) && enable && tmr_zero;
    assign tmr_en   = (state == WAIT) && enable;

    poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT;
            first_flag    <= 1'b1;
            value         <= '0;
            changed       <= 1'b0;
            avm.read      <= 1'b0;
            avm.write     <= 1'b0;
            avm.address   <= SRC_REG;
            avm.writedata <= '0;
        end else begin
            changed <= 1'b0;
            case (state)
                WAIT: begin
                    if (tmr_zero && enable) begin
                        state    <= RD;
                        avm.read <= 1'b1;
                    end
                end
                RD: begin
                    if (!avm.waitrequest) begin
                        state    <= LAT;
                        avm.read <= 1'b0;
                    end
                end
                LAT: begin
                    // readdata is valid in this cycle (latency 1 after acceptance).
                    if (sample != value || first_flag) begin
                        value         <= sample;
                        changed       <= 1'b1;
                        first_flag    <= 1'b0;
                        state         <= WR;
                        avm.write     <= 1'b1;
                        avm.address   <= DST_ADDR;
                        avm.writedata <= 32'(sample);
                    end else begin
                        state <= WAIT;
                    end
                end
                WR: begin
                    if (!avm.waitrequest) begin
                        state       <= WAIT;
                        avm.write   <= 1'b0;
                        avm.address <= SRC_REG;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_pio_poller.sv
module tb_avalon_pio_poller;
    localparam int          P   = 4;
    localparam logic [15:0] SRC = 16'h0000;
    localparam logic [15:0] DST = 16'h0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [17:0] value;
    logic        changed;
    logic [31:0] sw;

    avalon_pio_poller_if #(.ADDR_W(16)) bus ();

    avalon_pio_poller #(
        .POLL_DIV (P),
        .ADDR_W   (16),
        .SRC_ADDR (SRC),
        .DST_ADDR (DST),
        .DATA_W   (18)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .avm     (bus.master),
        .value   (value),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Slave model + bus monitor
    int          n_rd = 0, n_wr = 0, n_chg = 0;
    logic [15:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        overlap = 1'b0, addr_bad = 1'b0;

    always @(posedge clk) begin
        if (bus.read && !bus.waitrequest) begin
            n_rd         <= n_rd + 1;
            bus.readdata <= sw;
        end else begin
            bus.readdata <= 32'hDEAD_BEEF;
        end
        if (bus.write && !bus.waitrequest) begin
            n_wr    <= n_wr + 1;
            wr_addr <= bus.address;
            wr_data <= bus.writedata;
        end
        if (changed) n_chg <= n_chg + 1;
        if (bus.read && bus.write) overlap <= 1'b1;
        if (!reset && !bus.write && bus.address != SRC) addr_bad <= 1'b1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_read(input string tag, input int exp_k);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.read && k < 200);
        chk(tag, k, exp_k);
    endtask

    int wr0, chg0, rd0;

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        bus.waitrequest = 1'b0;
        sw = 32'h0000_02A5;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", bus.read, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_addr", bus.address, SRC);
        chk("rst_wdata", bus.writedata, 0);
        chk("rst_value", value, 0);
        chk("rst_changed", changed, 0);
        reset = 1'b0;

        // First poll: forced write
        wait_read("first_rd_delay", P);
        chk("rd_addr", bus.address, SRC);
        @(negedge clk);                       // LAT
        chk("lat_no_chg", changed, 0);
        @(negedge clk);                       // WR
        chk("p1_changed", changed, 1);
        chk("p1_value", value, 18'h2A5);
        chk("p1_write", bus.write, 1);
        chk("p1_addr", bus.address, DST);
        chk("p1_wdata", bus.writedata, 32'h0000_02A5);
        @(negedge clk);                       // WAIT
        chk("p1_write_done", bus.write, 0);
        chk("p1_nwr", n_wr, 1);
        chk("p1_wr_addr", wr_addr, DST);
        chk("p1_wr_data", wr_data, 32'h0000_02A5);
        chk("p1_chg_once", n_chg, 1);

        // Second poll, unchanged value
        wait_read("p2_period", P);
        @(negedge clk);                       // LAT
        @(negedge clk);                       // WAIT
        chk("p2_no_write", bus.write, 0);
        chk("p2_nwr", n_wr, 1);
        chk("p2_nchg", n_chg, 1);
        chk("p2_nrd", n_rd, 2);

        // Changed value, write stalled 3 cycles
        sw = 32'h0003_FFFF;
        wait_read("p3_period", P);
        @(negedge clk);                       // LAT
        bus.waitrequest = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("p3_write_c%0d", i), bus.write, 1);
            chk($sformatf("p3_addr_c%0d", i), bus.address, DST);
            chk($sformatf("p3_wdata_c%0d", i), bus.writedata, 32'h0003_FFFF);
            chk($sformatf("p3_chg_c%0d", i), changed, (i == 1) ? 1 : 0);
        end
        bus.waitrequest = 1'b0;
        @(negedge clk);
        chk("p3_write_done", bus.write, 0);
        chk("p3_nwr", n_wr, 2);
        chk("p3_wr_data", wr_data, 32'h0003_FFFF);
        chk("p3_value", value, 18'h3FFFF);

        // Upper readdata bits ignored
        sw = 32'hFFFC_0001;
        wait_read("p4_period", P);
        @(negedge clk);
        @(negedge clk);                       // WR
        chk("p4_value", value, 18'h00001);
        chk("p4_wdata", bus.writedata, 32'h0000_0001);
        @(negedge clk);
        chk("p4_nwr", n_wr, 3);

        // Enable dropped during RD
        sw = 32'h0000_0155;
        wait_read("p5_period", P);
        enable = 1'b0;
        @(negedge clk);                       // LAT
        @(negedge clk);                       // WR
        chk("p5_write", bus.write, 1);
        @(negedge clk);
        chk("p5_nwr", n_wr, 4);
        chk("p5_value", value, 18'h155);
        rd0 = n_rd;
        repeat (10) @(negedge clk);
        chk("p5_paused_read", bus.read, 0);
        chk("p5_paused_nrd", n_rd, rd0);
        enable = 1'b1;
        wait_read("p5_resume", P);
        @(negedge clk);
        @(negedge clk);                       // WAIT, no write
        chk("p5b_nwr", n_wr, 4);

        // Reset during stalled WR
        sw = 32'h0000_00AA;
        wait_read("p6_period", P);
        @(negedge clk);                       // LAT
        bus.waitrequest = 1'b1;
        @(negedge clk);                       // WR
        chk("p6_write", bus.write, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("p6_rst_write", bus.write, 0);
        chk("p6_rst_addr", bus.address, SRC);
        chk("p6_rst_value", value, 0);
        chk("p6_no_completion", n_wr, 4);
        bus.waitrequest = 1'b0;
        sw = 32'h0000_0000;
        reset = 1'b0;
        wait_read("p7_first_rd", P);
        @(negedge clk);
        @(negedge clk);                       // WR forced by first_flag
        chk("p7_write", bus.write, 1);
        chk("p7_changed", changed, 1);
        chk("p7_wdata", bus.writedata, 0);
        @(negedge clk);
        chk("p7_nwr", n_wr, 5);

        chk("no_rd_wr_overlap", overlap, 0);
        chk("addr_src_outside_wr", addr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
